// File: rtl/display_scan_7seg_pkg.sv
// rtl/display_scan_7seg_pkg.sv - segment codes, scan state encoding and digit count for the 6-digit scanner
package display_scan_7seg_pkg;

    localparam int NUM_DIGITS = 6;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    localparam logic [5:0] AN_OFF   = 6'h3F;

    typedef enum logic {
        ST_SHOW  = 1'b0,
        ST_BLANK = 1'b1
    } state_t;

endpackage

// File: rtl/display_scan_7seg_bcd_to_7seg.sv
// rtl/display_scan_7seg_bcd_to_7seg.sv - combinational BCD to active-low 7-segment decoder
module bcd_to_7seg
    import display_scan_7seg_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Codes 10..15 show a dash so corrupt digits are visible rather than blank
    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/display_scan_7seg.sv
// rtl/display_scan_7seg.sv - 6-digit multiplexed 7-segment scanner with frame snapshot, blanking gap and colon
module display_scan_7seg
    import display_scan_7seg_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic       Clk,
    input  logic       Clear,
    input  logic [3:0] Q0,
    input  logic [3:0] Q1,
    input  logic [3:0] Q2,
    input  logic [3:0] Q3,
    input  logic [3:0] Q4,
    input  logic [3:0] Q5,
    input  logic       Lz_blank,
    output logic [6:0] Seg,
    output logic [5:0] An,
    output logic       Dp
);

    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX);

    logic [23:0]      w_q;
    logic [23:0]      r_s1, r_s2, r_s3, r_stable, r_shadow;
    logic             r_first;
    state_t           r_state, w_state_nxt;
    logic [2:0]       r_idx, w_idx_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             w_frame_start;
    logic [3:0]       w_digit;
    logic [6:0]       w_seg;
    logic [5:0]       w_an_show;
    logic             w_lz_hide;
    logic             w_colon;

    assign w_q = {Q5, Q4, Q3, Q2, Q1, Q0};

    // Digits ripple asynchronously; only a value seen on two consecutive synced samples is trusted
    always_ff @(posedge Clk or posedge Clear) begin
        if (Clear) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_s3     <= '0;
            r_stable <= '0;
            r_shadow <= '0;
            r_first  <= 1'b1;
        end else begin
            r_s1    <= w_q;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_first <= 1'b0;
            if (r_s2 == r_s3) begin
                r_stable <= r_s2;
            end
            if (r_first || w_frame_start) begin
                r_shadow <= r_stable;
            end
        end
    end

    always_ff @(posedge Clk or posedge Clear) begin
        if (Clear) begin
            r_state <= ST_SHOW;
            r_idx   <= 3'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_cnt_nxt     = r_cnt + CNT_W'(1);
        w_frame_start = 1'b0;
        case (r_state)
            ST_SHOW: begin
                if (r_cnt == CNT_W'(SCAN_DIV - 1)) begin
                    w_state_nxt = ST_BLANK;
                    w_cnt_nxt   = '0;
                end
            end
            ST_BLANK: begin
                if (r_cnt == CNT_W'(BLANK_CYC - 1)) begin
                    w_state_nxt = ST_SHOW;
                    w_cnt_nxt   = '0;
                    if (r_idx == 3'(NUM_DIGITS - 1)) begin
                        w_idx_nxt     = 3'd0;
                        w_frame_start = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_SHOW;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_digit = 4'h0;
        case (r_idx)
            3'd0:    w_digit = r_shadow[3:0];
            3'd1:    w_digit = r_shadow[7:4];
            3'd2:    w_digit = r_shadow[11:8];
            3'd3:    w_digit = r_shadow[15:12];
            3'd4:    w_digit = r_shadow[19:16];
            3'd5:    w_digit = r_shadow[23:20];
            default: w_digit = 4'h0;
        endcase
    end

    bcd_to_7seg u_bcd_to_7seg (
        .i_bcd (w_digit),
        .o_seg (w_seg)
    );

    assign w_an_show = ~(6'b000001 << r_idx);
    assign w_lz_hide = (r_idx == 3'd5) && Lz_blank && (w_digit == 4'h0);
    // Colon sits on the hours/minutes and minutes/seconds separators, toggling with seconds parity
    assign w_colon   = ((r_idx == 3'd2) || (r_idx == 3'd4)) && !r_shadow[0];

    always_ff @(posedge Clk or posedge Clear) begin
        if (Clear) begin
            Seg <= SEG_OFF;
            An  <= AN_OFF;
            Dp  <= 1'b1;
        end else if (r_state == ST_SHOW) begin
            An  <= w_an_show;
            Seg <= w_lz_hide ? SEG_OFF : w_seg;
            Dp  <= !w_colon;
        end else begin
            An  <= AN_OFF;
            Seg <= SEG_OFF;
            Dp  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_display_scan_7seg.sv
// tb/tb_display_scan_7seg.sv - randomized bench for display_scan_7seg against a cycle-index reference model
module tb_display_scan_7seg;

    localparam int S  = 4;
    localparam int B  = 2;
    localparam int P  = S + B;
    localparam int F  = 6 * P;

    logic        Clk = 1'b0;
    logic        Clear = 1'b0;
    logic [23:0] q_in = '0;
    logic        lz = 1'b0;
    logic [6:0]  Seg;
    logic [5:0]  An;
    logic        Dp;

    display_scan_7seg #(.SCAN_DIV(S), .BLANK_CYC(B)) dut (
        .Clk      (Clk),
        .Clear    (Clear),
        .Q0       (q_in[3:0]),
        .Q1       (q_in[7:4]),
        .Q2       (q_in[11:8]),
        .Q3       (q_in[15:12]),
        .Q4       (q_in[19:16]),
        .Q5       (q_in[23:20]),
        .Lz_blank (lz),
        .Seg      (Seg),
        .An       (An),
        .Dp       (Dp)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: k = clock edges since reset release, position in frame from plain arithmetic
    int          k;
    logic [23:0] m_stable;
    logic [23:0] m_shadow;
    logic [23:0] qh[$];

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] tbl [10];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        if (d > 4'd9) return 7'h3F;
        return tbl[d];
    endfunction

    task automatic model_reset();
        k        = 0;
        m_stable = '0;
        m_shadow = '0;
        qh.delete();
        repeat (3) qh.push_front(24'h0);
    endtask

    task automatic check_off(input string tag);
        check({tag, "_seg"}, int'(Seg), 'h7F);
        check({tag, "_an"},  int'(An),  'h3F);
        check({tag, "_dp"},  int'(Dp),  1);
    endtask

    task automatic step();
        logic       lz_now;
        int         c, d;
        logic [3:0] dig;
        logic [6:0] e_seg;
        logic [5:0] e_an;
        logic       e_dp;
        qh.push_front(q_in);
        lz_now = lz;
        @(posedge Clk);
        k++;
        c = (k - 1) % F;
        d = c / P;
        if ((c % P) >= S) begin
            e_seg = 7'h7F;
            e_an  = 6'h3F;
            e_dp  = 1'b1;
        end else begin
            dig   = m_shadow[d*4 +: 4];
            e_an  = 6'h3F & ~(6'h01 << d);
            e_seg = (d == 5 && lz_now && dig == 4'h0) ? 7'h7F : seg_of(dig);
            e_dp  = ((d == 2 || d == 4) && !m_shadow[0]) ? 1'b0 : 1'b1;
        end
        if (k == 1 || (k % F) == 0) m_shadow = m_stable;
        if (qh[2] == qh[3]) m_stable = qh[2];
        while (qh.size() > 6) void'(qh.pop_back());
        #1;
        check("seg", int'(Seg), int'(e_seg));
        check("an",  int'(An),  int'(e_an));
        check("dp",  int'(Dp),  int'(e_dp));
    endtask

    // Entered 1 time unit after an edge; Clear rises mid-cycle and must act without a clock
    task automatic do_reset();
        #2;
        Clear = 1'b1;
        #1;
        check_off("rst_async");
        repeat (3) begin
            @(posedge Clk);
            #1;
            check_off("rst_hold");
        end
        #1;
        Clear = 1'b0;
        model_reset();
    endtask

    initial begin
        #1;
        do_reset();

        // Digits Q5..Q0 = 1,5,4,3,2,1 with no leading-zero blanking
        q_in = {4'h1, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
        lz   = 1'b0;
        repeat (3 * F) step();

        // Hours tens zero with blanking, even seconds lights the colon
        q_in[23:20] = 4'h0;
        q_in[3:0]   = 4'h0;
        lz          = 1'b1;
        repeat (2 * F) step();

        q_in[15:12] = 4'hC;
        repeat (2 * F) step();

        // Mid-frame change while digit 3 is lit, then a one-cycle glitch on Q2
        while (((k - 1) % F) / P != 3) step();
        q_in[7:4] = 4'h7;
        repeat (3) step();
        q_in[11:8] = 4'h9;
        step();
        q_in[11:8] = 4'h3;
        repeat (2 * F) step();

        while (((k - 1) % F) / P != 3 || ((k - 1) % P) >= S) step();
        do_reset();
        repeat (2 * F) step();

        for (int i = 0; i < 60; i++) begin
            int hold;
            hold = $urandom_range(1, 60);
            for (int j = 0; j < 6; j++) q_in[j*4 +: 4] = 4'($urandom_range(0, 15));
            lz = 1'($urandom_range(0, 1));
            repeat (hold) step();
            if ($urandom_range(0, 3) == 0) begin
                logic [23:0] keep;
                keep = q_in;
                q_in = 24'($urandom);
                step();
                q_in = keep;
                step();
            end
            if ($urandom_range(0, 9) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
